// File: rtl/mem_pkg.sv
// Shared types and widths for the pattern game datapath: player FSM states,
// pattern/count widths, and timer sizing used by pattern_player.
package mem_pkg;

  typedef enum logic [1:0] {PP_IDLE, PP_SHOW, PP_GAP, PP_DONE} pp_state_t;

  localparam int PAT_W = 32;
  localparam int CNT_W = 16;

  // Keeps the timer at least one bit wide when both phases last one cycle.
  function automatic int timer_w(input int on_c, input int gap_c);
    int m;
    m = (on_c > gap_c) ? on_c : gap_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pattern_player_if.sv
// Control/status bundle between the game FSM and pattern_player.
// The replay input exists only when PATTERN_PLAYER_REPLAY_EN is defined.
interface pattern_player_if #(
  parameter int PAT_W = mem_pkg::PAT_W,
  parameter int CNT_W = mem_pkg::CNT_W
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] length;
`ifdef PATTERN_PLAYER_REPLAY_EN
  logic             replay;
`endif
  logic             led_valid;
  logic             led_bit;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             done;

`ifdef PATTERN_PLAYER_REPLAY_EN
  modport master (output start, abort, pattern, length, replay,
                  input  led_valid, led_bit, bit_idx, busy, done);
  modport slave  (input  start, abort, pattern, length, replay,
                  output led_valid, led_bit, bit_idx, busy, done);
`else
  modport master (output start, abort, pattern, length,
                  input  led_valid, led_bit, bit_idx, busy, done);
  modport slave  (input  start, abort, pattern, length,
                  output led_valid, led_bit, bit_idx, busy, done);
`endif
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; zero is high while the count is 0.
// A load takes effect on the next edge; the count holds at 0 until reloaded.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_value;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Plays a latched pattern oldest-bit-first: ON_CYCLES lit, GAP_CYCLES blank per bit, then a done pulse.
// Optional replay input under macro PATTERN_PLAYER_REPLAY_EN.
module pattern_player #(
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PAT_W      = mem_pkg::PAT_W,
  parameter int CNT_W      = mem_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pattern_player_if.slave  io
);
  import mem_pkg::*;

  localparam int TW = timer_w(ON_CYCLES, GAP_CYCLES);
  localparam int IW = $clog2(PAT_W);

  pp_state_t        state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_clamp;
  logic [IW-1:0]    sel;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .zero       (tmr_zero)
  );

  assign len_clamp = (io.length > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : io.length;
  // Bit currently on display, counted from the oldest end of the pattern.
  assign sel = IW'(len_q - idx_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PP_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(ON_CYCLES - 1);
    unique case (state_q)
      PP_IDLE: begin
        if (!io.abort) begin
          if (io.start) begin
            pat_d    = io.pattern;
            len_d    = len_clamp;
            idx_d    = '0;
            tmr_load = 1'b1;
            state_d  = (len_clamp == '0) ? PP_DONE : PP_SHOW;
          end
`ifdef PATTERN_PLAYER_REPLAY_EN
          else if (io.replay) begin
            idx_d    = '0;
            tmr_load = 1'b1;
            state_d  = (len_q == '0) ? PP_DONE : PP_SHOW;
          end
`endif
        end
      end
      PP_SHOW: begin
        if (io.abort) begin
          state_d = PP_IDLE;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
          state_d  = PP_GAP;
        end
      end
      PP_GAP: begin
        if (io.abort) begin
          state_d = PP_IDLE;
        end else if (tmr_zero) begin
          if (idx_q == len_q - CNT_W'(1)) begin
            state_d = PP_DONE;
          end else begin
            idx_d    = idx_q + CNT_W'(1);
            tmr_load = 1'b1;
            state_d  = PP_SHOW;
          end
        end
      end
      PP_DONE: state_d = PP_IDLE;
      default: state_d = PP_IDLE;
    endcase
  end

  always_comb begin
    io.led_valid = 1'b0;
    io.led_bit   = 1'b0;
    io.bit_idx   = idx_q;
    io.busy      = (state_q != PP_IDLE);
    io.done      = 1'b0;
    if (state_q == PP_SHOW) begin
      io.led_valid = 1'b1;
      io.led_bit   = pat_q[sel];
    end
    if (state_q == PP_DONE) io.done = 1'b1;
  end

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: expected LED bits queued at start, popped as each bit appears.
module tb_pattern_player;
  localparam int ON  = 4;
  localparam int GAP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_idx;
  int   done_cnt;
  logic exp_q[$];

  pattern_player_if #(.PAT_W(32), .CNT_W(16)) io ();

  pattern_player #(
    .ON_CYCLES(ON), .GAP_CYCLES(GAP), .PAT_W(32), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pattern(input logic [31:0] pat, input int len);
    int n;
    n = (len > 32) ? 32 : len;
    for (int i = 0; i < n; i++) exp_q.push_back(pat[n-1-i]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 io.start = 1'b1;
    @(posedge clk); #1 io.start = 1'b0;
  endtask

  // Follows one playback from the cycle after start, checking bits, timing and the done pulse.
  task automatic observe(input int exp_busy, input int budget);
    int   busy_cnt = 0;
    int   run = 0;
    int   gap = 0;
    int   idx = 0;
    logic prev = 1'b0;
    logic e;
    logic seen = 1'b0;
    last_idx = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!io.busy) break;
      busy_cnt++;
      if (io.led_valid) begin
        if (!prev) begin
          if (idx > 0) check("gap_len", gap, GAP);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
          check("led_bit", io.led_bit, e);
          check("bit_idx", io.bit_idx, idx);
          last_idx = io.bit_idx;
          idx++;
          run = 0;
        end
        run++;
      end else begin
        if (prev) begin
          check("on_len", run, ON);
          gap = 0;
        end
        check("led_bit_blank", io.led_bit, 0);
        if (io.done) begin
          seen = 1'b1;
          check("done_cycle", busy_cnt, exp_busy);
          if (idx > 0) check("gap_len_last", gap, GAP);
        end else begin
          gap++;
        end
      end
      prev = io.led_valid;
    end
    check("done_seen", seen, 1);
    check("busy_span", busy_cnt, exp_busy);
    check("idle_after", io.busy, 0);
    check("done_after", io.done, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    io.start   = 1'b0;
    io.abort   = 1'b0;
    io.pattern = '0;
    io.length  = '0;
`ifdef PATTERN_PLAYER_REPLAY_EN
    io.replay  = 1'b0;
`endif
    #2;
    check("rst_led_valid", io.led_valid, 0);
    check("rst_led_bit", io.led_bit, 0);
    check("rst_bit_idx", io.bit_idx, 0);
    check("rst_busy", io.busy, 0);
    check("rst_done", io.done, 0);
    #20 rst_n = 1'b1;

`ifdef PATTERN_PLAYER_REPLAY_EN
    // Replay with nothing latched yet behaves as an empty pattern.
    @(posedge clk); #1 io.replay = 1'b1;
    @(posedge clk); #1 io.replay = 1'b0;
    observe(1, 10);
`endif

    // Basic playback: bits 1,0,1.
    io.pattern = 32'h5; io.length = 16'd3;
    push_pattern(32'h5, 3);
    pulse_start();
    observe(19, 40);

    // Zero length: immediate done, one busy cycle.
    io.length = 16'd0;
    pulse_start();
    observe(1, 10);

    // Clamp to 32 bits; input changes and a second start mid-playback are ignored.
    io.pattern = 32'hFFFF_FFFF; io.length = 16'd40;
    push_pattern(32'hFFFF_FFFF, 40);
    pulse_start();
    fork
      observe(193, 300);
      begin
        repeat (50) @(posedge clk);
        #1 io.pattern = '0; io.start = 1'b1;
        @(posedge clk); #1 io.start = 1'b0;
      end
    join
    check("clamp_last_idx", last_idx, 31);

    // Abort and start together in IDLE: abort wins.
    @(posedge clk); #1 io.start = 1'b1; io.abort = 1'b1;
    @(posedge clk); #1 io.start = 1'b0; io.abort = 1'b0;
    @(negedge clk);
    check("abort_start_idle", io.busy, 0);

    // Abort during the second SHOW of a 5-bit run (1,1,0,1,0).
    io.pattern = 32'h1A; io.length = 16'd5;
    pulse_start();
    repeat (7) @(posedge clk);
    #1 io.abort = 1'b1;
    @(negedge clk);
    check("abort_pre_valid", io.led_valid, 1);
    check("abort_pre_idx", io.bit_idx, 1);
    check("abort_pre_bit", io.led_bit, 1);
    @(posedge clk); #1 io.abort = 1'b0;
    @(negedge clk);
    check("abort_valid", io.led_valid, 0);
    check("abort_bit", io.led_bit, 0);
    check("abort_busy", io.busy, 0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    push_pattern(32'h1A, 5);
    pulse_start();
    observe(31, 60);

    // Asynchronous reset during the second gap.
    io.pattern = 32'h5; io.length = 16'd3;
    pulse_start();
    repeat (11) @(posedge clk);
    #2;
    check("rst_mid_busy", io.busy, 1);
    check("rst_mid_gap", io.led_valid, 0);
    check("rst_mid_idx", io.bit_idx, 1);
    rst_n = 1'b0;
    #1;
    check("arst_led_valid", io.led_valid, 0);
    check("arst_led_bit", io.led_bit, 0);
    check("arst_bit_idx", io.bit_idx, 0);
    check("arst_busy", io.busy, 0);
    check("arst_done", io.done, 0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", io.busy, 0);
    push_pattern(32'h5, 3);
    pulse_start();
    observe(19, 40);

`ifdef PATTERN_PLAYER_REPLAY_EN
    // Replay of the last latched pattern ignores the current inputs.
    io.pattern = 32'h3; io.length = 16'd2;
    push_pattern(32'h3, 2);
    pulse_start();
    observe(13, 30);
    io.pattern = '0; io.length = '0;
    push_pattern(32'h3, 2);
    @(posedge clk); #1 io.replay = 1'b1;
    @(posedge clk); #1 io.replay = 1'b0;
    observe(13, 30);
    // Start takes priority over replay: new inputs (bits 1,0) are used.
    io.pattern = 32'h2; io.length = 16'd2;
    push_pattern(32'h2, 2);
    @(posedge clk); #1 io.replay = 1'b1; io.start = 1'b1;
    @(posedge clk); #1 io.replay = 1'b0; io.start = 1'b0;
    observe(13, 30);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Output end of the player interface. The input capture path shifts user guesses in, MSB-first into the LSB.
- This block plays the current game pattern out to the player's LED/buzzer as a timed bit sequence, oldest bit first.
- Sits between the pattern shift register, the score counter and the game FSM.
- The FSM starts it after each pattern generation and enables user input only once `done` has pulsed.

Parameters:
- ON_CYCLES, 4, cycles each bit is shown (led_valid high); ≥1.
- GAP_CYCLES, 2, blank cycles after each bit (led_valid low); ≥1.
- PAT_W, 32, pattern register width.
- CNT_W, 16, width of the length/count input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin playback; sampled only in IDLE.
- abort  input  1  cancel playback immediately; no done pulse.
- pattern  input  PAT_W  game pattern; newest bit at [0].
- length  input  CNT_W  number of bits to play; values >PAT_W are clamped to PAT_W.
- led_valid  output  1  high while a bit is being shown.
- led_bit  output  1  value of the bit being shown; 0 when led_valid is low.
- bit_idx  output  CNT_W  0-based index (in play order) of the current bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  single-cycle pulse after the final gap.

Behaviour:
- Reset: all outputs 0; state IDLE; internal pattern, length, timer and index registers cleared.
- States and transitions:
  - IDLE → SHOW when start=1 and clamped length ≠ 0. Latch pattern and length; bit_idx=0; timer=ON_CYCLES-1.
  - IDLE → DONE when start=1 and length=0. No bit is shown; done pulses on the next cycle.
  - SHOW: led_valid=1; led_bit = latched pattern[len-1-bit_idx]. When the timer reaches 0, go to GAP with timer=GAP_CYCLES-1.
  - GAP: led_valid=0. When the timer reaches 0:
    - If bit_idx = len-1, go to DONE.
    - Otherwise increment bit_idx, go to SHOW with timer=ON_CYCLES-1.
  - DONE: done=1 for exactly one cycle → IDLE. busy remains 1 in DONE.
- Latency:
  - First led_valid appears the cycle after start is sampled.
  - Total busy span for length L≥1 is L*(ON_CYCLES+GAP_CYCLES)+1 cycles, including the DONE cycle.
- start while busy: ignored. Pattern or length changes while busy: ignored, because the values were latched at start.
- abort in any non-IDLE state: next state IDLE; led_valid, led_bit and busy drop next cycle; no done pulse.
- abort and start asserted together in IDLE: abort wins and the block stays IDLE.
- Async reset mid-playback: outputs clear immediately and the block returns to IDLE.
- Arithmetic: timer is unsigned and sized $clog2(max(ON,GAP)). bit_idx never exceeds len-1. No wrap-around is possible because length is clamped.

Optional Feature:
- Macro: PATTERN_PLAYER_REPLAY_EN.
- When defined:
  - Adds input `replay` (1 bit).
  - replay=1 in IDLE replays the last latched pattern and length without resampling the inputs.
  - replay before any start, or after reset, behaves as length=0 (immediate done).
  - start has priority over replay.
- When undefined: no replay port exists and the latched registers are only loaded by start.

Decomposition:
- Shared package mem_pkg holds:
  - typedef enum logic [1:0] {PP_IDLE, PP_SHOW, PP_GAP, PP_DONE} pp_state_t
  - localparams PAT_W=32 and CNT_W=16, shared with the input capture and score counter.
- One sub-module, cycle_timer: loadable down-counter with load, load_value and a zero flag. It is instantiated once and reloaded between SHOW and GAP.

Test Plan:
- Basic playback: ON=4, GAP=2, pattern=32'h5 (…101), length=3, start pulse.
  - Expected: led_bit sequence 1,0,1; each shown 4 cycles with 2-cycle gaps.
  - Expected: done pulses exactly 19 cycles after start; busy is low afterwards.
- Zero length: length=0, start pulse → no led_valid, done on the next cycle, busy high for exactly 1 cycle.
- Clamp and mid-playback changes: length=40, pattern=32'hFFFF_FFFF.
  - Expected: 32 bits shown, all 1, and bit_idx reaches 31.
  - Change pattern to 0 and pulse start mid-playback → output is unaffected.
- Abort: assert abort during the second SHOW of a length=5 run.
  - Expected: led_valid=0 and busy=0 on the next cycle; no done pulse; a subsequent start plays normally from bit_idx 0.
- Reset mid-operation: drop rst_n asynchronously during a GAP.
  - Expected: all outputs 0 without waiting for a clock edge; state IDLE after release.
- Replay (PATTERN_PLAYER_REPLAY_EN): play pattern=32'h3 with length=2, then set inputs to 0/0 and pulse replay.
  - Expected: bits 1,1 are shown again.
  - Expected: replay and start asserted together → start's inputs are used.
